// File: rtl/pc_addr_unit.sv
// pc_addr_unit: 6502 program counter (PCL/PCH) with its incrementer and carry,
// the external address bus register (ABL/ABH), and the PC byte drivers onto
// the ADL, ADH and DB internal buses.

package pc_addr_pkg;

  // Control word fields consumed by the PC / address-bus stage. Each bit is
  // one transfer "switch" named source_destination, as in the 6502 diagram.
  typedef struct packed {
    logic adl_pcl;  // ADL bus -> PCL select
    logic adh_pch;  // ADH bus -> PCH select
    logic pcl_pcl;  // PCL recirculates into PCL select
    logic pch_pch;  // PCH recirculates into PCH select
    logic i_pc;     // increment PC
    logic adl_abl;  // ADL bus -> ABL
    logic adh_abh;  // ADH bus -> ABH
    logic pcl_adl;  // PCL drives ADL bus
    logic pch_adh;  // PCH drives ADH bus
    logic pcl_db;   // PCL drives DB
    logic pch_db;   // PCH drives DB
  } control_signals_t;

endpackage

module pc_addr_unit
  import pc_addr_pkg::*;
#(
  parameter logic [15:0] RESET_PC = 16'h0000,
  parameter logic [15:0] RESET_AB = 16'h0000
) (
  input  logic             clk,
  input  logic             rst_n,
  input  control_signals_t ctl,
  input  logic             rdy,
  input  logic [7:0]       adl_in,
  input  logic [7:0]       adh_in,
  output logic [7:0]       pcl,
  output logic [7:0]       pch,
  output logic [15:0]      addr,
  output logic [7:0]       pc_adl,
  output logic             pc_adl_oe,
  output logic [7:0]       pc_adh,
  output logic             pc_adh_oe,
  output logic [7:0]       pc_db,
  output logic             pc_db_oe,
  output logic             pcl_carry,
  output logic             ctl_conflict
);

  // State
  logic [7:0] r_pcl;
  logic [7:0] r_pch;
  logic [7:0] r_abl;
  logic [7:0] r_abh;
  logic       r_pcl_carry;

  // Next-state datapath
  logic [7:0] w_sel_l;
  logic [7:0] w_sel_h;
  logic [8:0] w_inc_l;
  logic [7:0] w_nl;
  logic       w_cl;
  logic [7:0] w_nh;

  // PCL/PCL and PCH/PCH are the default recirculation paths: whenever the
  // bus-load select is clear the register feeds itself, so these two bits
  // carry no extra information for this stage.
  logic w_unused_ctl;
  assign w_unused_ctl = ctl.pcl_pcl ^ ctl.pch_pch;

  // Source select for both PC bytes and the 8+8 bit incrementer with carry.
  // NOTE: every signal assigned in always_comb gets a default first so a
  // missed branch can never infer a latch.
  always_comb begin
    w_sel_l = r_pcl;
    w_sel_h = r_pch;
    if (ctl.adl_pcl) begin
      w_sel_l = adl_in;
    end
    if (ctl.adh_pch) begin
      w_sel_h = adh_in;
    end
    w_inc_l = {1'b0, w_sel_l} + {8'h00, ctl.i_pc};
    w_nl    = w_inc_l[7:0];
    w_cl    = w_inc_l[8];
    // The high byte wraps modulo 256, so FFFF + 1 rolls over to 0000.
    w_nh    = w_sel_h + {7'h00, w_cl};
  end

  // PC and carry registers: load/increment on every ready edge.
  // NOTE: sequential state uses non-blocking assignments so all registers
  // sample their inputs from before the edge, regardless of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_pcl       <= RESET_PC[7:0];
      r_pch       <= RESET_PC[15:8];
      r_pcl_carry <= 1'b0;
    end else if (rdy) begin
      r_pcl       <= w_nl;
      r_pch       <= w_nh;
      r_pcl_carry <= w_cl;
    end
  end

  // Address bus registers: each byte captures its internal bus when enabled.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_abl <= RESET_AB[7:0];
      r_abh <= RESET_AB[15:8];
    end else if (rdy) begin
      if (ctl.adl_abl) begin
        r_abl <= adl_in;
      end
      if (ctl.adh_abh) begin
        r_abh <= adh_in;
      end
    end
  end

  // Bus drivers and the illegal-combination flag, straight from current
  // register contents and the current control word (zero latency).
  always_comb begin
    pc_db = 8'h00;
    if (ctl.pcl_db) begin
      pc_db = r_pcl;
    end else if (ctl.pch_db) begin
      pc_db = r_pch;
    end
    ctl_conflict = (ctl.pcl_db  & ctl.pch_db)
                 | (ctl.adl_pcl & ctl.pcl_adl)
                 | (ctl.adh_pch & ctl.pch_adh);
  end

  assign pc_adl    = r_pcl;
  assign pc_adh    = r_pch;
  assign pc_adl_oe = ctl.pcl_adl;
  assign pc_adh_oe = ctl.pch_adh;
  assign pc_db_oe  = ctl.pcl_db | ctl.pch_db;

  assign pcl       = r_pcl;
  assign pch       = r_pch;
  assign addr      = {r_abh, r_abl};
  assign pcl_carry = r_pcl_carry;

endmodule

// File: tb/tb_pc_addr_unit.sv
// Self-checking bench for pc_addr_unit: directed scenarios with literal
// expectations plus randomized control words checked every cycle against a
// 16-bit arithmetic model of the PC and address register.

module tb_pc_addr_unit;
  import pc_addr_pkg::*;

  logic             clk;
  logic             rst_n;
  control_signals_t ctl;
  logic             rdy;
  logic [7:0]       adl_in;
  logic [7:0]       adh_in;
  logic [7:0]       pcl;
  logic [7:0]       pch;
  logic [15:0]      addr;
  logic [7:0]       pc_adl;
  logic             pc_adl_oe;
  logic [7:0]       pc_adh;
  logic             pc_adh_oe;
  logic [7:0]       pc_db;
  logic             pc_db_oe;
  logic             pcl_carry;
  logic             ctl_conflict;

  pc_addr_unit #(
    .RESET_PC(16'h0000),
    .RESET_AB(16'h0000)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .ctl         (ctl),
    .rdy         (rdy),
    .adl_in      (adl_in),
    .adh_in      (adh_in),
    .pcl         (pcl),
    .pch         (pch),
    .addr        (addr),
    .pc_adl      (pc_adl),
    .pc_adl_oe   (pc_adl_oe),
    .pc_adh      (pc_adh),
    .pc_adh_oe   (pc_adh_oe),
    .pc_db       (pc_db),
    .pc_db_oe    (pc_db_oe),
    .pcl_carry   (pcl_carry),
    .ctl_conflict(ctl_conflict)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;
  logic chk_en = 1'b0;

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference model: the PC as one 16-bit number, the address as another.
  logic [15:0] m_pc;
  logic [15:0] m_ab;
  logic        m_c;
  logic [15:0] m_base;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_pc = 16'h0000;
      m_ab = 16'h0000;
      m_c  = 1'b0;
    end else if (rdy) begin
      m_base = {(ctl.adh_pch ? adh_in : m_pc[15:8]), (ctl.adl_pcl ? adl_in : m_pc[7:0])};
      m_c    = ctl.i_pc && (m_base[7:0] == 8'hFF);
      m_pc   = m_base + {15'd0, ctl.i_pc};
      if (ctl.adl_abl) m_ab[7:0]  = adl_in;
      if (ctl.adh_abh) m_ab[15:8] = adh_in;
    end
  end

  // Compare process: every output, every cycle, on the falling edge.
  logic [7:0] e_db;
  always @(negedge clk) begin
    if (chk_en) begin
      e_db = ctl.pcl_db ? m_pc[7:0] : (ctl.pch_db ? m_pc[15:8] : 8'h00);
      check("pc",        {pch, pcl},            m_pc);
      check("addr",      addr,                  m_ab);
      check("pcl_carry", {15'd0, pcl_carry},    {15'd0, m_c});
      check("pc_adl",    {8'd0, pc_adl},        {8'd0, m_pc[7:0]});
      check("pc_adh",    {8'd0, pc_adh},        {8'd0, m_pc[15:8]});
      check("pc_db",     {8'd0, pc_db},         {8'd0, e_db});
      check("oe",        {13'd0, pc_adl_oe, pc_adh_oe, pc_db_oe},
                         {13'd0, ctl.pcl_adl, ctl.pch_adh, ctl.pcl_db | ctl.pch_db});
      check("conflict",  {15'd0, ctl_conflict},
                         {15'd0, (ctl.pcl_db & ctl.pch_db) | (ctl.adl_pcl & ctl.pcl_adl)
                                 | (ctl.adh_pch & ctl.pch_adh)});
    end
  end

  task automatic step(input control_signals_t c, input logic [7:0] al,
                      input logic [7:0] ah, input logic r);
    ctl    = c;
    adl_in = al;
    adh_in = ah;
    rdy    = r;
    @(posedge clk);
    #1;
  endtask

  task automatic load_pc(input logic [15:0] v);
    control_signals_t c;
    c         = '0;
    c.adl_pcl = 1'b1;
    c.adh_pch = 1'b1;
    step(c, v[7:0], v[15:8], 1'b1);
  endtask

  initial begin
    control_signals_t c;
    logic [15:0] exp_addr [3];
    logic [31:0] r;
    exp_addr[0] = 16'h80FE;
    exp_addr[1] = 16'h80FF;
    exp_addr[2] = 16'h8100;

    rst_n  = 1'b0;
    ctl    = '0;
    rdy    = 1'b1;
    adl_in = 8'h00;
    adh_in = 8'h00;
    @(posedge clk);
    #1;
    chk_en = 1'b1;
    check("reset_pc", {pch, pcl}, 16'h0000);
    rst_n = 1'b1;

    // Asynchronous reset in the middle of a cycle.
    load_pc(16'h1234);
    check("load_1234", {pch, pcl}, 16'h1234);
    #2 rst_n = 1'b0;
    #1;
    check("rst_async_pc",    {pch, pcl},          16'h0000);
    check("rst_async_addr",  addr,                16'h0000);
    check("rst_async_carry", {15'd0, pcl_carry},  16'h0000);
    @(posedge clk);
    #1 rst_n = 1'b1;

    // Sequential fetch with ADL/ADH looped back from the PC drivers.
    load_pc(16'h80FE);
    c = '0;
    c.pcl_pcl = 1'b1; c.pch_pch = 1'b1; c.i_pc    = 1'b1;
    c.pcl_adl = 1'b1; c.pch_adh = 1'b1; c.adl_abl = 1'b1; c.adh_abh = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step(c, m_pc[7:0], m_pc[15:8], 1'b1);
      check("fetch_addr",  addr,               exp_addr[i]);
      check("fetch_carry", {15'd0, pcl_carry}, (i == 1) ? 16'h0001 : 16'h0000);
    end
    check("fetch_pc_end", {pch, pcl}, 16'h8101);

    // Wrap FFFF -> 0000.
    load_pc(16'hFFFF);
    c = '0;
    c.pcl_pcl = 1'b1; c.pch_pch = 1'b1; c.i_pc = 1'b1;
    step(c, 8'h00, 8'h00, 1'b1);
    check("wrap_pc",    {pch, pcl},         16'h0000);
    check("wrap_carry", {15'd0, pcl_carry}, 16'h0001);

    // Jump load, then jump plus increment.
    c = '0;
    c.adl_pcl = 1'b1; c.adh_pch = 1'b1;
    step(c, 8'h34, 8'h12, 1'b1);
    check("jump_pc", {pch, pcl}, 16'h1234);
    c.i_pc = 1'b1;
    step(c, 8'h34, 8'h12, 1'b1);
    check("jump_inc_pc", {pch, pcl}, 16'h1235);

    // Stall: nothing moves while rdy is low.
    c = '0;
    c.i_pc = 1'b1; c.adl_abl = 1'b1;
    for (int i = 0; i < 4; i++) begin
      step(c, 8'h77, 8'h66, 1'b0);
      check("stall_pc",   {pch, pcl}, 16'h1235);
      check("stall_addr", addr,       16'h8100);
    end
    step(c, 8'h77, 8'h66, 1'b1);
    check("resume_pc",   {pch, pcl}, 16'h1236);
    check("resume_addr", addr,       16'h8177);

    // DB drive and conflict flag.
    load_pc(16'hABCD);
    c = '0; c.pch_db = 1'b1; ctl = c; #1;
    check("db_pch",    {8'd0, pc_db},       16'h00AB);
    check("db_pch_oe", {15'd0, pc_db_oe},   16'h0001);
    c = '0; c.pcl_db = 1'b1; ctl = c; #1;
    check("db_pcl",    {8'd0, pc_db},       16'h00CD);
    c.pch_db = 1'b1; ctl = c; #1;
    check("db_both",      {8'd0, pc_db},        16'h00CD);
    check("db_conflict",  {15'd0, ctl_conflict}, 16'h0001);
    c = '0; ctl = c; #1;
    check("db_none",    {8'd0, pc_db},     16'h0000);
    check("db_none_oe", {15'd0, pc_db_oe}, 16'h0000);
    @(posedge clk);
    #1;

    // Randomized control words, with an occasional fetch-style loopback
    // and one reset pulse in the middle.
    for (int i = 0; i < 400; i++) begin
      r = $urandom;
      c = r[10:0];
      if (r[15:13] == 3'b000) begin
        step(c, m_pc[7:0], m_pc[15:8], r[20:16] != 5'd0);
      end else begin
        step(c, r[31:24], r[23:16], r[12:11] != 2'b00);
      end
      if (i == 200) begin
        #2 rst_n = 1'b0;
        #1 check("rand_rst_pc", {pch, pcl}, 16'h0000);
        @(posedge clk);
        #1 rst_n = 1'b1;
      end
    end

    @(negedge clk);
    #1;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/pc_addr_unit.md
# pc_addr_unit

Program counter and address bus register stage of the 6502 core. It sits directly downstream of the decode/timing logic and consumes the PC- and address-related fields of `control_signals_t`: ADL/PCL, ADH/PCH, PCL/PCL, PCH/PCH, I/PC, ADL/ABL, ADH/ABH, PCL/ADL, PCH/ADH, PCL/DB and PCH/DB. It holds PCL, PCH, ABL and ABH, runs the PC incrementer with its carry, and returns the PC bytes to the ADL, ADH and DB internal buses.

## Interface

Parameters:
- `RESET_PC`, default 16'h0000: PC value loaded at reset.
- `RESET_AB`, default 16'h0000: address bus value loaded at reset.

Ports:
- `clk`, in, 1: core clock; all state updates on the rising edge.
- `rst_n`, in, 1: asynchronous active-low reset.
- `ctl`, in, `control_signals_t`: control word for the current cycle. Only the eleven fields named above are used.
- `rdy`, in, 1: when 0, all registers hold.
- `adl_in`, in, 8: current ADL bus value.
- `adh_in`, in, 8: current ADH bus value.
- `pcl`, out, 8: PCL register.
- `pch`, out, 8: PCH register.
- `addr`, out, 16: external address, {ABH, ABL}.
- `pc_adl`, out, 8: PCL value driven onto ADL.
- `pc_adl_oe`, out, 1: PCL drives ADL; equals `ctl.pcl_adl`.
- `pc_adh`, out, 8: PCH value driven onto ADH.
- `pc_adh_oe`, out, 1: PCH drives ADH; equals `ctl.pch_adh`.
- `pc_db`, out, 8: PC byte driven onto DB.
- `pc_db_oe`, out, 1: equals `ctl.pcl_db | ctl.pch_db`.
- `pcl_carry`, out, 1: registered carry out of the PCL increment.
- `ctl_conflict`, out, 1: combinational flag for illegal control combinations.

## Operation

**Low-byte source**
- `sel_l` = `adl_in` if `adl_pcl`, otherwise PCL.
- ADL/PCL wins over PCL/PCL when both are set.
- When neither is set, the low byte behaves as PCL/PCL.

**Low-byte increment**
- {cl, nl} = `sel_l` + `i_pc`, computed as 9-bit arithmetic.

**High-byte source**
- `sel_h` = `adh_in` if `adh_pch`, otherwise PCH.
- ADH/PCH wins over PCH/PCH when both are set.

**High-byte increment**
- nh = (`sel_h` + cl) mod 256.
- PC wraps from 16'hFFFF to 16'h0000.

**Register updates** (rising edge, when `rdy`=1)
- PCL ← nl, PCH ← nh, `pcl_carry` ← cl.
- ABL ← `adl_in` when `adl_abl`; otherwise holds.
- ABH ← `adh_in` when `adh_abh`; otherwise holds.

**Bus drivers** (combinational from current registers, not next-state)
- `pc_adl` = PCL, `pc_adh` = PCH.
- `pc_db` = PCL if `pcl_db`, else PCH if `pch_db`, else 8'h00.

**`ctl_conflict`** is asserted in any of these cases:
- `pcl_db` and `pch_db` both set;
- `adl_pcl` and `pcl_adl` both set (bus self-loop);
- `adh_pch` and `pch_adh` both set.
- The flag is informational only; operation still follows the priority rules above.

**Hold**
- `rdy`=0 freezes PCL, PCH, ABL, ABH and `pcl_carry`.
- Drivers and `ctl_conflict` keep following `ctl`.

## Timing

- **Reset** (asynchronous, immediate on `rst_n` low):
  - {PCH, PCL} = `RESET_PC`, `addr` = `RESET_AB`, `pcl_carry` = 0.
  - Drivers follow `ctl` even during reset.
- **Reset release:** registers resume on the first rising edge with `rst_n`=1.
- **Reset mid-operation:** an in-flight increment is discarded; there is no partial update.
- **Register latency:**
  - PC, AB and `pcl_carry` update one edge after the cycle in which `ctl` is asserted.
  - Values are visible on outputs in the following cycle.
- **Driver latency:** `pc_*` drivers and `*_oe` are zero-latency (same cycle as `ctl`).
- **Same-cycle load and drive:** when PCL/ADL and ADL/ABL are set together, ABL captures `adl_in`. The external ADL mux must place `pc_adl` on `adl_in`. This is the standard fetch cycle: one cycle, PC to AB.
- **Simultaneous increment and load:** `adl_pcl` with `i_pc`=1 loads `adl_in`+1 (jump plus increment in one edge).
- **Page-crossing carry:** cl=1 increments PCH in the same edge. `pcl_carry` is valid for exactly the cycle after that edge.

## Test plan

1. **Reset:** assert `rst_n`=0 mid-cycle with PC=16'h1234.
   - PC=16'h0000 and `addr`=16'h0000 immediately; `pcl_carry`=0.
2. **Sequential fetch:** PC=16'h80FE; assert `pcl_pcl`, `pch_pch`, `i_pc`, `pcl_adl`, `pch_adh`, `adl_abl`, `adh_abh` for 3 cycles, with `adl_in`/`adh_in` looped from `pc_adl`/`pc_adh`.
   - `addr` sequence: 80FE, 80FF, 8100.
   - PC ends at 8101.
   - `pcl_carry`=1 only in the cycle after the FF→00 edge.
3. **Wrap:** PC=16'hFFFF with `i_pc`=1.
   - PC=16'h0000 and `pcl_carry`=1.
4. **Jump load:** `adl_in`=8'h34, `adh_in`=8'h12, `adl_pcl`=`adh_pch`=1, `i_pc`=0.
   - PC=16'h1234 next cycle.
   - Repeating with `i_pc`=1 gives 16'h1235.
5. **Stall:** `rdy`=0 for 4 cycles with `i_pc`=1 and `adl_abl`=1.
   - PC and `addr` unchanged throughout.
   - Resumes incrementing on the first cycle with `rdy`=1.
6. **DB drive and conflict:** PC=16'hABCD.
   - `pch_db`: `pc_db`=8'hAB, `pc_db_oe`=1.
   - `pcl_db`: `pc_db`=8'hCD.
   - Both set: `pc_db`=8'hCD and `ctl_conflict`=1.
   - Neither set: `pc_db`=8'h00, `pc_db_oe`=0.
